// File: rtl/power_seq_gen.sv
// Power-sequence generator: emits n^2 or n^3 for n = 1, 2, 3, ... over a valid/ready
// handshake, built from forward differences and stopped by a term count or by overflow.
module power_seq_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             mode_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] val_o,
    output logic             valid_o,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [WIDTH:0] MAX_VAL = {1'b0, {WIDTH{1'b1}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [WIDTH:0]   d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, lim_q, lim_d;
    logic             last_q, last_d, done_q, done_d, ovf_q, ovf_d;

    logic             start_ok_s, accept_s, ovf_now_s, nlast_s;
    logic [WIDTH:0]   sum_s, nd1_s, nd2_s, nsum_s;
    logic [CNT_W-1:0] ncnt_s;

    assign start_ok_s = (state_q == S_IDLE) && start_i && !abort_i;
    assign accept_s   = (state_q == S_RUN) && ready_i && !abort_i;
    assign sum_s      = {1'b0, val_q} + d1_q;
    assign nd1_s      = d1_q + d2_q;
    assign nd2_s      = d2_q + d3_q;
    assign ovf_now_s  = (sum_s > MAX_VAL) || (d1_q > MAX_VAL);
    // Lookahead one term so last_o can be registered alongside the term it qualifies
    assign nsum_s     = {1'b0, sum_s[WIDTH-1:0]} + nd1_s;
    assign ncnt_s     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1'b1);
    assign nlast_s    = ((lim_q != '0) && (ncnt_s == lim_q)) ||
                        (nsum_s > MAX_VAL) || (nd1_s > MAX_VAL);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort has priority over any acceptance
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok_s) state_d = S_RUN;
                else            state_d = S_IDLE;
            end
            S_RUN: begin
                if (abort_i)                state_d = S_IDLE;
                else if (ready_i && last_q) state_d = S_IDLE;
                else                        state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy_o  = (state_q == S_RUN);
        valid_o = (state_q == S_RUN);
        val_o   = val_q;
        last_o  = last_q;
        done_o  = done_q;
        ovf_o   = ovf_q;
    end

    // Datapath next-state: difference-engine init, advance and termination
    always_comb begin
        val_d  = val_q;
        d1_d   = d1_q;
        d2_d   = d2_q;
        d3_d   = d3_q;
        cnt_d  = cnt_q;
        lim_d  = lim_q;
        last_d = last_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        if (start_ok_s) begin
            val_d  = WIDTH'(1'b1);
            d1_d   = mode_i ? (WIDTH+1)'(4'd7)  : (WIDTH+1)'(4'd3);
            d2_d   = mode_i ? (WIDTH+1)'(4'd12) : (WIDTH+1)'(4'd2);
            d3_d   = mode_i ? (WIDTH+1)'(4'd6)  : (WIDTH+1)'(4'd0);
            cnt_d  = CNT_W'(1'b1);
            lim_d  = count_i;
            last_d = (count_i == CNT_W'(1'b1));
            ovf_d  = 1'b0;
        end else if ((state_q == S_RUN) && abort_i) begin
            last_d = 1'b0;
        end else if (accept_s && last_q) begin
            done_d = 1'b1;
            ovf_d  = ovf_now_s;
            last_d = 1'b0;
        end else if (accept_s) begin
            val_d  = sum_s[WIDTH-1:0];
            d1_d   = nd1_s;
            d2_d   = nd2_s;
            cnt_d  = ncnt_s;
            last_d = nlast_s;
        end else begin
            done_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_q  <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            d3_q   <= '0;
            cnt_q  <= '0;
            lim_q  <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            val_q  <= val_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            d3_q   <= d3_d;
            cnt_q  <= cnt_d;
            lim_q  <= lim_d;
            last_q <= last_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule
